// File: rtl/zigbee_cordic_arbiter.sv
// Round-robin arbiter sharing one pipelined phase CORDIC between two I/Q requesters.
// Define ZIGBEE_CORDIC_ARB_PRIO_EN for fixed priority (requester 0 always wins ties).
module zigbee_cordic_arbiter #(
    parameter int IQ_SIZE    = 5,
    parameter int W_SIZE     = 6,
    parameter int CORDIC_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [IQ_SIZE-1:0] req0_ibb,
    input  logic [IQ_SIZE-1:0] req0_qbb,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [IQ_SIZE-1:0] req1_ibb,
    input  logic [IQ_SIZE-1:0] req1_qbb,
    output logic [IQ_SIZE-1:0] cor_ibb,
    output logic [IQ_SIZE-1:0] cor_qbb,
    input  logic [W_SIZE-1:0]  cor_wout,
    output logic               res0_valid,
    output logic [W_SIZE-1:0]  res0_w,
    output logic               res1_valid,
    output logic [W_SIZE-1:0]  res1_w,
    output logic               busy
);

    localparam int TAG_DEPTH = CORDIC_LAT + 1;

    logic                 g0, g1;
    logic                 last_grant_q, last_grant_d;
    logic [IQ_SIZE-1:0]   cor_ibb_q, cor_ibb_d;
    logic [IQ_SIZE-1:0]   cor_qbb_q, cor_qbb_d;
    logic [TAG_DEPTH-1:0] tag_vld_q, tag_vld_d;
    logic [TAG_DEPTH-1:0] tag_id_q, tag_id_d;
    logic                 res0_valid_q, res0_valid_d;
    logic                 res1_valid_q, res1_valid_d;
    logic [W_SIZE-1:0]    res0_w_q, res0_w_d;
    logic [W_SIZE-1:0]    res1_w_q, res1_w_d;

    // Grant is purely combinational from the request valids; it never looks at ready.
    always_comb begin
`ifdef ZIGBEE_CORDIC_ARB_PRIO_EN
        g0 = enable & req0_valid;
        g1 = enable & req1_valid & ~req0_valid;
`else
        g0 = enable & req0_valid & (~req1_valid |  last_grant_q);
        g1 = enable & req1_valid & (~req0_valid | ~last_grant_q);
`endif
    end

    // NOTE: every *_d gets a value on every path (hold defaults first), so no latches are inferred.
    always_comb begin
        last_grant_d = last_grant_q;
        cor_ibb_d    = cor_ibb_q;
        cor_qbb_d    = cor_qbb_q;
        if (g0) begin
            last_grant_d = 1'b0;
            cor_ibb_d    = req0_ibb;
            cor_qbb_d    = req0_qbb;
        end else if (g1) begin
            last_grant_d = 1'b1;
            cor_ibb_d    = req1_ibb;
            cor_qbb_d    = req1_qbb;
        end

        // The CORDIC never stalls, so the tag pipeline shifts on every edge.
        tag_vld_d = {tag_vld_q[TAG_DEPTH-2:0], g0 | g1};
        tag_id_d  = {tag_id_q[TAG_DEPTH-2:0], g1};

        res0_valid_d = tag_vld_q[CORDIC_LAT] & ~tag_id_q[CORDIC_LAT];
        res1_valid_d = tag_vld_q[CORDIC_LAT] &  tag_id_q[CORDIC_LAT];
        res0_w_d     = res0_valid_d ? cor_wout : res0_w_q;
        res1_w_d     = res1_valid_d ? cor_wout : res1_w_q;
    end

    // NOTE: non-blocking assignments for all state so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            cor_ibb_q    <= '0;
            cor_qbb_q    <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            res0_valid_q <= 1'b0;
            res1_valid_q <= 1'b0;
            res0_w_q     <= '0;
            res1_w_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cor_ibb_q    <= cor_ibb_d;
            cor_qbb_q    <= cor_qbb_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            res0_valid_q <= res0_valid_d;
            res1_valid_q <= res1_valid_d;
            res0_w_q     <= res0_w_d;
            res1_w_q     <= res1_w_d;
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign cor_ibb    = cor_ibb_q;
    assign cor_qbb    = cor_qbb_q;
    assign res0_valid = res0_valid_q;
    assign res1_valid = res1_valid_q;
    assign res0_w     = res0_w_q;
    assign res1_w     = res1_w_q;
    assign busy       = |tag_vld_q;

endmodule

// File: tb/tb_zigbee_cordic_arbiter.sv
// Self-checking bench for zigbee_cordic_arbiter: behavioural CORDIC + transaction scoreboard.
module tb_zigbee_cordic_arbiter;

    localparam int IQ  = 5;
    localparam int W   = 6;
    localparam int LAT = 3;
    localparam int RES_DELAY = LAT + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [IQ-1:0] req0_ibb, req0_qbb, req1_ibb, req1_qbb;
    logic [IQ-1:0] cor_ibb, cor_qbb;
    logic [W-1:0]  cor_wout;
    logic          res0_valid, res1_valid, busy;
    logic [W-1:0]  res0_w, res1_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    zigbee_cordic_arbiter #(.IQ_SIZE(IQ), .W_SIZE(W), .CORDIC_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ibb(req0_ibb), .req0_qbb(req0_qbb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ibb(req1_ibb), .req1_qbb(req1_qbb),
        .cor_ibb(cor_ibb), .cor_qbb(cor_qbb), .cor_wout(cor_wout),
        .res0_valid(res0_valid), .res0_w(res0_w),
        .res1_valid(res1_valid), .res1_w(res1_w),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Ideal phase of (i,q): atan2 scaled to 64 steps per turn, wrapped to 6 bits.
    function automatic logic [W-1:0] phase_of(input logic signed [IQ-1:0] i, input logic signed [IQ-1:0] q);
        real a;
        int  r;
        a = $atan2(real'(q), real'(i)) / (2.0 * 3.14159265358979) * 64.0;
        r = $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
        return r[W-1:0];
    endfunction

    // Behavioural external CORDIC: samples cor_ibb/cor_qbb, wout stable LAT edges later.
    logic [W-1:0] cpipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        cpipe[0] <= phase_of(cor_ibb, cor_qbb);
        for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    end
    assign cor_wout = cpipe[LAT-1];

    // Scoreboard: each accepted sample becomes one expected strobe RES_DELAY cycles later.
    typedef struct {
        int           due;
        logic         id;
        logic [W-1:0] w;
    } exp_t;

    exp_t          sb[$];
    logic          m_last = 1'b1;
    logic [W-1:0]  m_w0 = '0, m_w1 = '0;
    logic [IQ-1:0] m_ci = '0, m_cq = '0;

    always @(negedge clk) begin
        logic e_g0, e_g1, e_r0, e_r1, e_busy;
        if (reset) begin
            sb.delete();
            m_last = 1'b1;
            m_w0 = '0; m_w1 = '0; m_ci = '0; m_cq = '0;
            check("rst_res0_valid", res0_valid, 0);
            check("rst_res1_valid", res1_valid, 0);
            check("rst_busy", busy, 0);
        end else begin
`ifdef ZIGBEE_CORDIC_ARB_PRIO_EN
            e_g0 = enable && req0_valid;
            e_g1 = enable && req1_valid && !req0_valid;
`else
            e_g0 = enable && req0_valid && (!req1_valid || m_last == 1'b1);
            e_g1 = enable && req1_valid && (!req0_valid || m_last == 1'b0);
`endif
            check("req0_ready", req0_ready, e_g0);
            check("req1_ready", req1_ready, e_g1);
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                if (sb[0].id) begin e_r1 = 1'b1; m_w1 = sb[0].w; end
                else          begin e_r0 = 1'b1; m_w0 = sb[0].w; end
                void'(sb.pop_front());
            end
            e_busy = 1'b0;
            foreach (sb[k]) if (sb[k].due - cyc >= 1 && sb[k].due - cyc <= RES_DELAY - 1) e_busy = 1'b1;
            check("res0_valid", res0_valid, e_r0);
            check("res1_valid", res1_valid, e_r1);
            check("res0_w", res0_w, m_w0);
            check("res1_w", res1_w, m_w1);
            check("busy", busy, e_busy);
            check("cor_ibb", cor_ibb, m_ci);
            check("cor_qbb", cor_qbb, m_cq);
            if (e_g0) begin
                sb.push_back('{due: cyc + RES_DELAY, id: 1'b0, w: phase_of(req0_ibb, req0_qbb)});
                m_ci = req0_ibb; m_cq = req0_qbb; m_last = 1'b0;
            end else if (e_g1) begin
                sb.push_back('{due: cyc + RES_DELAY, id: 1'b1, w: phase_of(req1_ibb, req1_qbb)});
                m_ci = req1_ibb; m_cq = req1_qbb; m_last = 1'b1;
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        int n_g0, n_g1, n_s0, n_s1;
        reset = 1'b1; enable = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_ibb = '0; req0_qbb = '0; req1_ibb = '0; req1_qbb = '0;
        #1;
        check("reset_cor_ibb", cor_ibb, 0);
        check("reset_res0_w", res0_w, 0);
        check("reset_busy", busy, 0);
        tick(2);
        reset = 1'b0;
        enable = 1'b1;
        tick(1);

        // Requester 0 alone: phase of (7,0) is 0, strobe RES_DELAY cycles after the grant cycle.
        req0_valid = 1'b1; req0_ibb = 5'sd7; req0_qbb = '0;
        #1;
        check("t1_ready", req0_ready, 1);
        tick(1);
        req0_valid = 1'b0;
        tick(RES_DELAY - 1);
        check("t1_res0_valid", res0_valid, 1);
        check("t1_res0_w", res0_w, 0);
        check("t1_res1_valid", res1_valid, 0);
        tick(1);
        check("t1_res0_one_cycle", res0_valid, 0);
        tick(3);

        // Requester 1 alone: (-8,0) is 180 degrees.
        req1_valid = 1'b1; req1_ibb = 5'b11000; req1_qbb = '0;
        tick(1);
        req1_valid = 1'b0;
        tick(RES_DELAY - 1);
        check("t2_res1_valid", res1_valid, 1);
        check("t2_res1_w", res1_w, 6'b100000);
        tick(3);

        // Both valid for 8 cycles straight after reset.
        pulse_reset();
        n_g0 = 0; n_g1 = 0;
        for (int k = 0; k < 8; k++) begin
            req0_valid = 1'b1; req0_ibb = 5'(k + 1);  req0_qbb = 5'(2 * k - 7);
            req1_valid = 1'b1; req1_ibb = 5'(-k - 1); req1_qbb = 5'(3 - k);
            #1;
            n_g0 += int'(req0_ready);
            n_g1 += int'(req1_ready);
            tick(1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ZIGBEE_CORDIC_ARB_PRIO_EN
        check("t3_grants0", n_g0, 8);
        check("t3_grants1", n_g1, 0);
`else
        check("t3_grants0", n_g0, 4);
        check("t3_grants1", n_g1, 4);
`endif
        tick(10);

        // Four-sample stream, then enable drops while req0 keeps asking.
        n_s0 = 0;
        for (int k = 0; k < 14; k++) begin
            enable = (k < 4);
            req0_valid = 1'b1; req0_ibb = 5'(-k); req0_qbb = 5'(k + 2);
            #1;
            if (k >= 4) check("t4_no_ready", req0_ready, 0);
            n_s0 += int'(res0_valid);
            tick(1);
        end
        check("t4_strobes", n_s0, 4);
        check("t4_busy_end", busy, 0);
        req0_valid = 1'b0; enable = 1'b1;
        tick(3);

        // Reset two cycles after three accepts: everything clears at once, no stale strobes.
        req1_valid = 1'b1; req1_ibb = 5'sd3; req1_qbb = 5'sd5;
        tick(3);
        req1_valid = 1'b0;
        tick(2);
        reset = 1'b1;
        #1;
        check("t5_res1_valid", res1_valid, 0);
        check("t5_res1_w", res1_w, 0);
        check("t5_res0_w", res0_w, 0);
        check("t5_cor_ibb", cor_ibb, 0);
        check("t5_cor_qbb", cor_qbb, 0);
        check("t5_busy", busy, 0);
        tick(2);
        reset = 1'b0;
        n_s0 = 0; n_s1 = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            n_s0 += int'(res0_valid);
            n_s1 += int'(res1_valid);
        end
        check("t5_no_strobes", n_s0 + n_s1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
